// File: rtl/rx_cic_decim_iq.sv
// Dual-channel (I/Q) N-stage CIC decimator with settings-bus programmable rate and gain normalisation.
// Build option: define CIC_DECIM_ROUND_EN for round-half-up before the output shift (default: truncate).
module rx_cic_decim_iq #(
    parameter logic [7:0]  BASE      = 8'd0,
    parameter int unsigned WIDTH     = 18,
    parameter int unsigned N         = 4,
    parameter int unsigned ACC_WIDTH = 50
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    set_stb,
    input  logic [7:0]              set_addr,
    input  logic [31:0]             set_data,
    input  logic                    run,
    input  logic signed [WIDTH-1:0] i_in,
    input  logic signed [WIDTH-1:0] q_in,
    output logic signed [WIDTH-1:0] i_out,
    output logic signed [WIDTH-1:0] q_out,
    output logic                    strobe_out
);

    localparam int unsigned SW = $clog2(N * 8 + 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        (ACC_WIDTH+1)'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

    logic [8:0]                  rate_q, rate_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic [N-1:0]                dv_q, dv_d;
    logic                        comb_vld_q, comb_vld_d;
    logic signed [ACC_WIDTH-1:0] integ_q [2][N];
    logic signed [ACC_WIDTH-1:0] integ_d [2][N];
    logic signed [ACC_WIDTH-1:0] dly_q   [2][N];
    logic signed [ACC_WIDTH-1:0] dly_d   [2][N];
    logic signed [ACC_WIDTH-1:0] comb_q  [2];
    logic signed [ACC_WIDTH-1:0] comb_d  [2];
    logic signed [ACC_WIDTH-1:0] cw_c    [2][N+1];
    logic signed [ACC_WIDTH-1:0] x_c     [2];
    logic signed [WIDTH-1:0]     i_out_q, i_out_d, q_out_q, q_out_d;
    logic                        strobe_q, strobe_d;
    logic                        rate_wr_c, clear_c, dec_c;
    logic [SW-1:0]               shift_c;
    logic                        unused_set_hi;

    assign unused_set_hi = ^set_data[31:9];

    function automatic logic [3:0] ceil_log2(input logic [8:0] r);
        ceil_log2 = 4'd0;
        for (int k = 0; k < 9; k++) begin
            if ((9'd1 << k) < r) ceil_log2 = 4'(k + 1);
        end
    endfunction

    function automatic logic [8:0] rate_decode(input logic [8:0] v);
        if (v == 9'd0)        rate_decode = 9'd1;
        else if (v > 9'd256)  rate_decode = 9'd256;
        else                  rate_decode = v;
    endfunction

    // Arithmetic shift by S with optional rounding, then saturate to WIDTH.
    function automatic logic signed [WIDTH-1:0] norm(input logic signed [ACC_WIDTH-1:0] x,
                                                     input logic [SW-1:0] s);
        logic signed [ACC_WIDTH:0] t;
        t = {x[ACC_WIDTH-1], x};
`ifdef CIC_DECIM_ROUND_EN
        if (s != '0) t = t + ((ACC_WIDTH+1)'(1) << (s - SW'(1)));
`endif
        t = t >>> s;
        if (t > SAT_MAX)      norm = WIDTH'(SAT_MAX);
        else if (t < SAT_MIN) norm = WIDTH'(SAT_MIN);
        else                  norm = t[WIDTH-1:0];
    endfunction

    assign rate_wr_c = set_stb && (set_addr == BASE);
    assign clear_c   = !run || rate_wr_c;
    assign shift_c   = SW'(N * 32'(ceil_log2(rate_q)));
    assign dec_c     = ({1'b0, cnt_q} == (rate_q - 9'd1)) && (rate_q != 9'd1);
    assign x_c[0]    = ACC_WIDTH'(i_in);
    assign x_c[1]    = ACC_WIDTH'(q_in);

    // Next-state: integrators at input rate, comb chain advancing on the delayed decimation flag.
    always_comb begin
        rate_d     = rate_q;
        cnt_d      = cnt_q;
        dv_d       = dv_q;
        comb_vld_d = comb_vld_q;
        integ_d    = integ_q;
        dly_d      = dly_q;
        comb_d     = comb_q;
        cw_c       = '{default: '{default: '0}};
        i_out_d    = i_out_q;
        q_out_d    = q_out_q;
        strobe_d   = 1'b0;

        if (rate_wr_c) rate_d = rate_decode(set_data[8:0]);

        cnt_d      = ({1'b0, cnt_q} == (rate_q - 9'd1)) ? 8'd0 : cnt_q + 8'd1;
        dv_d       = (dv_q << 1) | N'(dec_c);
        comb_vld_d = dv_q[N-1];

        for (int ch = 0; ch < 2; ch++) begin
            integ_d[ch][0] = integ_q[ch][0] + x_c[ch];
            for (int k = 1; k < N; k++) integ_d[ch][k] = integ_q[ch][k] + integ_q[ch][k-1];
            cw_c[ch][0] = integ_q[ch][N-1];
            for (int k = 0; k < N; k++) begin
                cw_c[ch][k+1] = cw_c[ch][k] - dly_q[ch][k];
                if (dv_q[N-1]) dly_d[ch][k] = cw_c[ch][k];
            end
            if (dv_q[N-1]) comb_d[ch] = cw_c[ch][N];
        end

        if (rate_q == 9'd1) begin
            i_out_d  = i_in;
            q_out_d  = q_in;
            strobe_d = 1'b1;
        end else if (comb_vld_q) begin
            i_out_d  = norm(comb_q[0], shift_c);
            q_out_d  = norm(comb_q[1], shift_c);
            strobe_d = 1'b1;
        end

        // Idle or rate change: flush everything in flight.
        if (clear_c) begin
            cnt_d      = '0;
            dv_d       = '0;
            comb_vld_d = 1'b0;
            integ_d    = '{default: '{default: '0}};
            dly_d      = '{default: '{default: '0}};
            comb_d     = '{default: '0};
            i_out_d    = '0;
            q_out_d    = '0;
            strobe_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rate_q     <= 9'd1;
            cnt_q      <= '0;
            dv_q       <= '0;
            comb_vld_q <= 1'b0;
            integ_q    <= '{default: '{default: '0}};
            dly_q      <= '{default: '{default: '0}};
            comb_q     <= '{default: '0};
            i_out_q    <= '0;
            q_out_q    <= '0;
            strobe_q   <= 1'b0;
        end else begin
            rate_q     <= rate_d;
            cnt_q      <= cnt_d;
            dv_q       <= dv_d;
            comb_vld_q <= comb_vld_d;
            integ_q    <= integ_d;
            dly_q      <= dly_d;
            comb_q     <= comb_d;
            i_out_q    <= i_out_d;
            q_out_q    <= q_out_d;
            strobe_q   <= strobe_d;
        end
    end

    assign i_out      = i_out_q;
    assign q_out      = q_out_q;
    assign strobe_out = strobe_q;

endmodule

// File: tb/tb_rx_cic_decim_iq.sv
// Bench for rx_cic_decim_iq: reference model convolves input history with the CIC impulse response.
module tb_rx_cic_decim_iq;

    localparam int unsigned WIDTH     = 18;
    localparam int unsigned N         = 4;
    localparam int unsigned ACC_WIDTH = 50;
    localparam logic [7:0]  BASE      = 8'd0;
    localparam int          HMAX      = 1024;
    localparam int          EMAX      = 65536;

    logic                    clk = 1'b0;
    logic                    rst, set_stb, run;
    logic [7:0]              set_addr;
    logic [31:0]             set_data;
    logic signed [WIDTH-1:0] i_in, q_in, i_out, q_out;
    logic                    strobe_out;

    rx_cic_decim_iq #(.BASE(BASE), .WIDTH(WIDTH), .N(N), .ACC_WIDTH(ACC_WIDTH)) dut (
        .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .run(run), .i_in(i_in), .q_in(q_in), .i_out(i_out), .q_out(q_out),
        .strobe_out(strobe_out)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;

    // model state
    int     m_r, m_s, h_len, m_n, e;
    longint h [HMAX];
    int     hist_i [HMAX];
    int     hist_q [HMAX];
    bit     exp_stb [EMAX];
    bit     exp_chk [EMAX];
    int     exp_i [EMAX];
    int     exp_q [EMAX];

    bit     rand_in, steady_en;
    int     steady_i, steady_q, stb_seen;

    task automatic chk_eq(input string tag, input longint got, input longint want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", tag, e, got, want);
        end
    endtask

    // Impulse response of N cascaded length-R boxcars, plus the normalising shift.
    function automatic void set_rate(input int v);
        longint t [HMAX];
        int     nl, c;
        if (v == 0) v = 1;
        if (v > 256) v = 256;
        m_r = v;
        c = 0;
        while ((1 << c) < m_r) c++;
        m_s = int'(N) * c;
        for (int j = 0; j < HMAX; j++) h[j] = 0;
        h[0]  = 1;
        h_len = 1;
        for (int st = 0; st < int'(N); st++) begin
            nl = h_len + m_r - 1;
            for (int k = 0; k < nl; k++) begin
                t[k] = 0;
                for (int j = 0; j < m_r; j++)
                    if (k - j >= 0 && k - j < h_len) t[k] += h[k-j];
            end
            for (int k = 0; k < nl; k++) h[k] = t[k];
            h_len = nl;
        end
    endfunction

    function automatic longint ref_norm(input longint y);
        longint one = 1;
        longint t   = y;
        longint mx  = (one <<< (WIDTH - 1)) - 1;
`ifdef CIC_DECIM_ROUND_EN
        if (m_s > 0) t = t + (one <<< (m_s - 1));
`endif
        t = t >>> m_s;
        if (t > mx) t = mx;
        if (t < -mx - 1) t = -mx - 1;
        return t;
    endfunction

    task automatic model_step();
        bit     wr;
        longint yi, yq;
        int     k;
        wr = set_stb && (set_addr == BASE);
        if (rst || !run || wr) begin
            for (int j = 0; j <= int'(N) + 1; j++) begin
                exp_stb[e+j] = 1'b0;
                exp_chk[e+j] = 1'b0;
            end
            if (rst || !run) begin
                exp_chk[e] = 1'b1;
                exp_i[e]   = 0;
                exp_q[e]   = 0;
            end
            if (rst)     set_rate(1);
            else if (wr) set_rate(int'(set_data[8:0]));
            m_n      = 0;
            stb_seen = 0;
        end else if (m_r == 1) begin
            exp_stb[e] = 1'b1;
            exp_chk[e] = 1'b1;
            exp_i[e]   = int'(i_in);
            exp_q[e]   = int'(q_in);
        end else begin
            hist_i[m_n % HMAX] = int'(i_in);
            hist_q[m_n % HMAX] = int'(q_in);
            if (m_n % m_r == m_r - 1) begin
                yi = 0;
                yq = 0;
                for (int j = 0; j < h_len && j <= m_n; j++) begin
                    yi += h[j] * longint'(hist_i[(m_n - j) % HMAX]);
                    yq += h[j] * longint'(hist_q[(m_n - j) % HMAX]);
                end
                k = e + int'(N) + 1;
                exp_stb[k] = 1'b1;
                exp_chk[k] = 1'b1;
                exp_i[k]   = int'(ref_norm(yi));
                exp_q[k]   = int'(ref_norm(yq));
            end
            m_n++;
        end
    endtask

    task automatic do_check();
        chk_eq("strobe", longint'(strobe_out), longint'(exp_stb[e]));
        if (exp_chk[e]) begin
            chk_eq("i_out", longint'(i_out), longint'(exp_i[e]));
            chk_eq("q_out", longint'(q_out), longint'(exp_q[e]));
        end
        if (exp_stb[e] && steady_en) begin
            stb_seen++;
            if (stb_seen >= int'(N) + 1) begin
                chk_eq("steady_i", longint'(i_out), longint'(steady_i));
                chk_eq("steady_q", longint'(q_out), longint'(steady_q));
            end
        end
    endtask

    task automatic tick();
        if (rand_in) begin
            i_in = WIDTH'($urandom);
            q_in = WIDTH'($urandom);
        end
        if (e + int'(N) + 2 >= EMAX) begin
            $display("FAIL cycle_budget: edge %0d exceeds %0d", e, EMAX);
            $fatal(1);
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
        do_check();
        e++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr_rate(input int v);
        set_stb  = 1'b1;
        set_addr = BASE;
        set_data = 32'(v);
        tick();
        set_stb  = 1'b0;
    endtask

    task automatic set_const(input int iv, input int qv);
        rand_in = 1'b0;
        i_in    = WIDTH'(iv);
        q_in    = WIDTH'(qv);
    endtask

    initial begin
        int r, len;
        e = 0; m_n = 0; stb_seen = 0;
        set_rate(1);
        rst = 1'b1; run = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
        rand_in = 1'b1; steady_en = 1'b0; steady_i = 0; steady_q = 0;
        i_in = '0; q_in = '0;
        @(negedge clk);

        // reset, including a rate write that reset must override
        run = 1'b1;
        ticks(2);
        wr_rate(4);
        rst = 1'b0;

        // 1: bypass
        set_const(1000, -1000);
        steady_en = 1'b1; steady_i = 1000; steady_q = -1000;
        ticks(12);
        rand_in = 1'b1; steady_en = 1'b0;
        ticks(20);

        // 2: R=4 constant
        set_const(1000, -1000);
        wr_rate(4);
        steady_en = 1'b1;
        ticks(60);

        // 3: R=3, gain 81/256
        set_const(100, 0);
        wr_rate(3);
`ifdef CIC_DECIM_ROUND_EN
        steady_i = 32;
`else
        steady_i = 31;
`endif
        steady_q = 0;
        ticks(40);
        set_const(2560, 0);
        wr_rate(3);
        steady_i = 810;
        ticks(40);

        // 4: R=256 full-scale
        set_const(131071, -131072);
        wr_rate(256);
        steady_i = 131071; steady_q = -131072;
        ticks(25 * 256 + 10);

        // 5: rate change mid-block
        set_const(1000, -1000);
        steady_i = 1000; steady_q = -1000;
        wr_rate(4);
        ticks(22);
        wr_rate(8);
        ticks(90);

        // 6: drop run mid-block, then restart
        wr_rate(4);
        ticks(18);
        run = 1'b0;
        ticks(6);
        run = 1'b1;
        ticks(50);

        // randomized: rates, data, run drops, foreign-address writes
        steady_en = 1'b0;
        rand_in   = 1'b1;
        for (int it = 0; it < 14; it++) begin
            r = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 400));
            if ($urandom_range(0, 5) == 0) run = 1'b0;
            wr_rate(r);
            run = 1'b1;
            len = int'($urandom_range(40, 450));
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 60) == 0) begin
                    run = 1'b0;
                    ticks(int'($urandom_range(1, 4)));
                    run = 1'b1;
                end else if ($urandom_range(0, 60) == 0) begin
                    set_stb  = 1'b1;
                    set_addr = 8'($urandom_range(1, 255));
                    set_data = $urandom;
                    tick();
                    set_stb  = 1'b0;
                end else begin
                    tick();
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
